// File: rtl/bcd_to_bin_seq.sv
// BcdToBinSeq: serial packed-BCD to binary converter using reverse double-dabble.
// A captured BCD word is shifted right into a binary field one bit per cycle.
// After each shift, every BCD nibble that reads 8 or more has 3 subtracted from it.
// After BW shifts the binary field holds the result and the BCD field has drained to zero.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BW     = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic [BW-1:0]         Bin,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);

  localparam int SW = 4*DIGITS + BW;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] shift_q, shift_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] bin_q, bin_d;
  logic          err_q, err_d;

  logic          anyBad;
  logic [SW-1:0] shifted;
  logic [SW-1:0] corrected;

  // Flag an incoming word that holds any digit above 9; such words bypass conversion.
  always_comb begin
    anyBad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (BCD[4*k +: 4] > 4'd9) begin
        anyBad = 1'b1;
      end
    end
  end

  // One reverse double-dabble step: shift right, then pull every nibble at 8 or above down by 3.
  // The subtraction cannot underflow because it only touches nibbles that are at least 8.
  always_comb begin
    shifted   = shift_q >> 1;
    corrected = shifted;
    for (int k = 0; k < DIGITS; k++) begin
      if (shifted[BW + 4*k +: 4] >= 4'd8) begin
        corrected[BW + 4*k +: 4] = shifted[BW + 4*k +: 4] - 4'd3;
      end
    end
  end

  // Next-state logic; DONE accepts a new Start exactly like IDLE so back-to-back words lose no cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          shift_d = {BCD, {BW{1'b0}}};
          count_d = '0;
          if (anyBad) begin
            bin_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CONV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        shift_d = corrected;
        count_d = count_q + CW'(1);
        if (count_q == CW'(BW - 1)) begin
          bin_d   = corrected[BW-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once, aborting any conversion.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign Bin  = bin_q;
  assign Err  = err_q;
  assign Busy = (state_q == CONV);
  assign Done = (state_q == DONE);

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq.
// Expected results go into a queue when a word is started.
// A negedge monitor pops and compares them whenever Done is seen.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 3;
  localparam int BW     = 10;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [11:0]   BCD;
  logic [BW-1:0] Bin;
  logic          Busy;
  logic          Done;
  logic          Err;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic          err;
  } exp_t;

  typedef struct {
    logic [11:0]   bcd;
    logic [BW-1:0] bin;
    logic          err;
  } vec_t;

  exp_t          expQ[$];
  int            applied;
  int            miscompares;
  int            doneCount;
  logic [BW-1:0] heldBin;
  logic          heldErr;
  logic          prevBusy;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BW(BW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .BCD   (BCD),
    .Bin   (Bin),
    .Busy  (Busy),
    .Done  (Done),
    .Err   (Err)
  );

  // Free-running clock, period 10.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: compares results on Done.
  // It also checks that Bin and Err hold between Done pulses.
  // At the end of every real conversion it checks that the internal BCD field has drained.
  always @(negedge Clock) begin
    if (Reset) begin
      heldBin  = '0;
      heldErr  = 1'b0;
      prevBusy = 1'b0;
    end else begin
      if (Done) begin
        doneCount++;
        if (expQ.size() == 0) begin
          applied++;
          miscompares++;
          $display("[TB] FAIL unexpectedDone: got Bin=%0d Err=%0d, expected no Done", Bin, Err);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("Bin", 32'(Bin), 32'(e.bin));
          checkOutput("Err", 32'(Err), 32'(e.err));
          heldBin = e.bin;
          heldErr = e.err;
        end
        if (prevBusy) begin
          applied++;
          assert (dut.shift_q[BW +: 4*DIGITS] == '0)
          else begin
            miscompares++;
            $display("[TB] FAIL bcdFieldDrained: got %0h, expected 0", dut.shift_q[BW +: 4*DIGITS]);
          end
        end
      end else begin
        checkOutput("BinHold", 32'(Bin), 32'(heldBin));
        checkOutput("ErrHold", 32'(Err), 32'(heldErr));
      end
      prevBusy = Busy;
    end
  end

  // Start one word with a single-cycle Start pulse.
  // Waits (bounded) for Done, then checks latency and Busy length.
  task automatic applyStimulus(input logic [11:0] bcd, input logic [BW-1:0] expBin, input logic expErr);
    int n;
    int busyCycles;
    @(negedge Clock);
    BCD   = bcd;
    Start = 1'b1;
    expQ.push_back('{bin: expBin, err: expErr});
    @(negedge Clock);
    Start = 1'b0;
    n = 0;
    busyCycles = 0;
    while (!Done && n < 50) begin
      if (Busy) busyCycles++;
      n++;
      @(negedge Clock);
    end
    checkOutput("latency", 32'(n), expErr ? 32'd0 : 32'(BW));
    checkOutput("busyCycles", 32'(busyCycles), expErr ? 32'd0 : 32'(BW));
  endtask

  // Bounded wait for the next Done pulse; returns the number of cycles waited.
  task automatic waitDone(output int n);
    n = 0;
    while (!Done && n < 50) begin
      n++;
      @(negedge Clock);
    end
    checkOutput("doneSeen", 32'(Done), 32'd1);
  endtask

  // Main sequence: reset checks, vector table, multi-cycle corner cases, then an exhaustive sweep.
  initial begin
    vec_t vecs[10];
    int   n;
    int   doneBefore;

    vecs[0] = '{bcd: 12'h999, bin: 10'd999, err: 1'b0};
    vecs[1] = '{bcd: 12'h000, bin: 10'd0,   err: 1'b0};
    vecs[2] = '{bcd: 12'h012, bin: 10'd12,  err: 1'b0};
    vecs[3] = '{bcd: 12'h100, bin: 10'd100, err: 1'b0};
    vecs[4] = '{bcd: 12'h1A5, bin: 10'd0,   err: 1'b1};
    vecs[5] = '{bcd: 12'h105, bin: 10'd105, err: 1'b0};
    vecs[6] = '{bcd: 12'hF00, bin: 10'd0,   err: 1'b1};
    vecs[7] = '{bcd: 12'h00A, bin: 10'd0,   err: 1'b1};
    vecs[8] = '{bcd: 12'h808, bin: 10'd808, err: 1'b0};
    vecs[9] = '{bcd: 12'h090, bin: 10'd90,  err: 1'b0};

    applied     = 0;
    miscompares = 0;
    doneCount   = 0;
    heldBin     = '0;
    heldErr     = 1'b0;
    prevBusy    = 1'b0;
    Reset       = 1'b1;
    Start       = 1'b0;
    BCD         = '0;

    repeat (2) @(negedge Clock);
    checkOutput("resetBin",  32'(Bin),  32'd0);
    checkOutput("resetBusy", 32'(Busy), 32'd0);
    checkOutput("resetDone", 32'(Done), 32'd0);
    checkOutput("resetErr",  32'(Err),  32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].bcd, vecs[i].bin, vecs[i].err);
    end

    // Start and BCD changes during CONV are ignored.
    @(negedge Clock);
    doneBefore = doneCount;
    BCD   = 12'h250;
    Start = 1'b1;
    expQ.push_back('{bin: 10'd250, err: 1'b0});
    @(negedge Clock);
    Start = 1'b0;
    BCD   = 12'h777;
    repeat (3) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    waitDone(n);
    repeat (15) @(negedge Clock);
    checkOutput("singleDone", 32'(doneCount - doneBefore), 32'd1);

    // Back-to-back: Start held high, second word captured in DONE.
    @(negedge Clock);
    doneBefore = doneCount;
    BCD   = 12'h321;
    Start = 1'b1;
    expQ.push_back('{bin: 10'd321, err: 1'b0});
    expQ.push_back('{bin: 10'd654, err: 1'b0});
    @(negedge Clock);
    waitDone(n);
    checkOutput("b2bFirstLatency", 32'(n), 32'(BW));
    BCD = 12'h654;
    @(negedge Clock);
    waitDone(n);
    checkOutput("b2bSpacing", 32'(n + 1), 32'(BW + 1));
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    checkOutput("b2bDoneCount", 32'(doneCount - doneBefore), 32'd2);

    // Asynchronous reset in the middle of a conversion.
    @(negedge Clock);
    doneBefore = doneCount;
    BCD   = 12'h123;
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(posedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("abortBin",  32'(Bin),  32'd0);
    checkOutput("abortBusy", 32'(Busy), 32'd0);
    checkOutput("abortDone", 32'(Done), 32'd0);
    checkOutput("abortErr",  32'(Err),  32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (15) @(negedge Clock);
    checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd0);
    applyStimulus(12'h042, 10'd42, 1'b0);

    // Every valid three-digit word.
    for (int v = 0; v < 1000; v++) begin
      logic [11:0] w;
      w = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      applyStimulus(w, 10'(v), 1'b0);
    end

    repeat (3) @(negedge Clock);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
